// File: rtl/regfile_mport.sv
// Multi-port register file: optional hardware-zero top register, write-to-read bypass, registered reads.
// Latency 0 (combinational) or 1 (READ_LATENCY=1, captured per port on rd_en); no backpressure.
module regfile_mport #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int NREAD        = 2,
  parameter bit ZERO_REG     = 1'b1,
  parameter bit BYPASS       = 1'b1,
  parameter int READ_LATENCY = 0,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NREAD-1:0]       rd_en,
  input  logic [NREAD*AW-1:0]    raddr,
  output logic [NREAD*WIDTH-1:0] rdata
);

  localparam int ZADDR = DEPTH - 1;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  // The zero register is never written, so its flop stays at its reset value and folds away.
  assign wr_ok = we && (32'(waddr) < DEPTH) && !(ZERO_REG && (32'(waddr) == ZADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] v;

    assign ra = raddr[p*AW +: AW];

    always_comb begin
      v = '0;
      if ((32'(ra) < DEPTH) && !(ZERO_REG && (32'(ra) == ZADDR))) begin
        if (BYPASS && wr_ok && (waddr == ra)) v = wdata;
        else                                  v = regs[ra];
      end
    end

    if (READ_LATENCY == 1) begin : g_reg
      logic [WIDTH-1:0] rdata_q;

      // v is taken before this edge's write lands; the bypass path alone makes it visible.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rdata_q <= '0;
        else if (rd_en[p]) rdata_q <= v;
      end

      assign rdata[p*WIDTH +: WIDTH] = rdata_q;
    end else begin : g_comb
      logic unused_rd_en;
      assign unused_rd_en            = rd_en[p];
      assign rdata[p*WIDTH +: WIDTH] = v;
    end
  end

endmodule
